vcompos_seq: RTL and testbench

//  Clocked sequencer that owns the rv_param bus of the analog voltage composer (N_DIV divider slots).

---
 rtl/vcompos_seq.sv | 199 +++++++++++++++++++
 tb/tb_vcompos_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vcompos_seq.sv
// Sequencer owning the composer's rv_param bus: round-robin accepts one slot-reprogram
// request at a time, applies ena/r at once and slews v toward its target in timed steps.
module vcompos_seq #(
   parameter int N_DIV  = 5,
   parameter int N_REQ  = 2,
   parameter int TICK_W = 8
) (
   input  logic                  clk,
   input  logic                  rstz,
   input  logic [N_REQ-1:0]      req_vld,
   output logic [N_REQ-1:0]      req_rdy,
   input  logic [N_REQ*3-1:0]    req_slot,
   input  logic [N_REQ-1:0]      req_ena,
   input  logic [N_REQ*24-1:0]   req_r,
   input  logic [N_REQ*16-1:0]   req_v,
   input  logic [N_REQ*16-1:0]   req_step,
   input  logic [TICK_W-1:0]     tick_div,
   input  logic                  abort,
   output logic [N_DIV*41-1:0]   rv_param,
   output logic [N_DIV-1:0]      busy,
   output logic                  done,
   output logic [2:0]            done_slot,
   output logic                  err
);

   localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_RAMP  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [RR_W-1:0]     r_rr;
   logic [RR_W-1:0]     w_win;
   logic [RR_W-1:0]     w_idx;
   logic                w_found;
   logic                w_accept;
   logic [N_REQ-1:0]    w_rdy;
   logic [2:0]          r_slot;
   logic                r_ena;
   logic [23:0]         r_res;
   logic [15:0]         r_tgt;
   logic [15:0]         r_step;
   logic [TICK_W-1:0]   r_tick;
   logic [TICK_W-1:0]   r_cnt;
   logic [40:0]         r_rv [N_DIV];
   logic [N_DIV-1:0]    r_busy;
   logic                r_done;
   logic [2:0]          r_done_slot;
   logic                r_err;
   logic                w_slot_ok;
   logic [2:0]          w_slot_idx;
   logic [15:0]         w_cur_v;
   logic [15:0]         w_diff;
   logic [15:0]         w_delta;
   logic [15:0]         w_next_v;
   logic                w_up;

   // Round-robin search starting at the pointer; grants only while idle and out of reset
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = RR_W'((int'(r_rr) + k) % N_REQ);
         if (!w_found && req_vld[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end else begin
            w_found = w_found;
         end
      end
      w_accept = w_found && (r_state == S_IDLE) && rstz;
      w_rdy    = '0;
      if (w_accept) begin
         w_rdy[w_win] = 1'b1;
      end else begin
         w_rdy = '0;
      end
   end

   assign req_rdy = w_rdy;

   // Ramp step toward target, clamped to the remaining distance
   always_comb begin
      w_slot_ok  = (int'(r_slot) < N_DIV);
      w_slot_idx = w_slot_ok ? r_slot : 3'd0;
      w_cur_v    = r_rv[w_slot_idx][15:0];
      if (r_tgt >= w_cur_v) begin
         w_up   = 1'b1;
         w_diff = r_tgt - w_cur_v;
      end else begin
         w_up   = 1'b0;
         w_diff = w_cur_v - r_tgt;
      end
      w_delta  = (r_step < w_diff) ? r_step : w_diff;
      w_next_v = w_up ? (w_cur_v + w_delta) : (w_cur_v - w_delta);
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_APPLY;
            else          w_state_nxt = S_IDLE;
         end
         S_APPLY: begin
            if (!w_slot_ok || !r_ena || (r_res == 24'd0) || (r_step == 16'd0) || (w_cur_v == r_tgt))
               w_state_nxt = S_DONE;
            else
               w_state_nxt = S_RAMP;
         end
         S_RAMP: begin
            if (abort)                                            w_state_nxt = S_DONE;
            else if ((r_cnt == TICK_W'(0)) && (w_next_v == r_tgt)) w_state_nxt = S_DONE;
            else                                                  w_state_nxt = S_RAMP;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Request latch, slot table, ramp timer and registered status outputs
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         r_rr        <= '0;
         r_slot      <= 3'd0;
         r_ena       <= 1'b0;
         r_res       <= 24'd0;
         r_tgt       <= 16'd0;
         r_step      <= 16'd0;
         r_tick      <= '0;
         r_cnt       <= '0;
         r_busy      <= '0;
         r_done      <= 1'b0;
         r_done_slot <= 3'd0;
         r_err       <= 1'b0;
         for (int i = 0; i < N_DIV; i++) r_rv[i] <= 41'd0;
      end else begin
         if (w_accept) begin
            r_slot <= req_slot[3*w_win +: 3];
            r_ena  <= req_ena[w_win];
            r_res  <= req_r[24*w_win +: 24];
            r_tgt  <= req_v[16*w_win +: 16];
            r_step <= req_step[16*w_win +: 16];
            r_tick <= tick_div;
            r_rr   <= (w_win == RR_W'(N_REQ-1)) ? RR_W'(0) : (w_win + RR_W'(1));
         end
         if ((r_state == S_APPLY) && w_slot_ok) begin
            if (!r_ena || (r_res == 24'd0)) begin
               r_rv[w_slot_idx] <= {r_ena, r_res, r_tgt};
            end else if ((r_step == 16'd0) || (w_cur_v == r_tgt)) begin
               r_rv[w_slot_idx] <= {1'b1, r_res, r_tgt};
            end else begin
               r_rv[w_slot_idx]   <= {1'b1, r_res, w_cur_v};
               r_busy[w_slot_idx] <= 1'b1;
               r_cnt              <= r_tick;
            end
         end
         if (r_state == S_RAMP) begin
            if (abort) begin
               r_busy[w_slot_idx] <= 1'b0;
            end else if (r_cnt == TICK_W'(0)) begin
               r_rv[w_slot_idx][15:0] <= w_next_v;
               r_cnt                  <= r_tick;
               if (w_next_v == r_tgt) r_busy[w_slot_idx] <= 1'b0;
            end else begin
               r_cnt <= r_cnt - TICK_W'(1);
            end
         end
         r_done <= (w_state_nxt == S_DONE);
         r_err  <= (w_state_nxt == S_DONE) && !w_slot_ok;
         if (w_state_nxt == S_DONE) r_done_slot <= r_slot;
      end
   end

   // Pack slot table onto the composer bus
   always_comb begin
      rv_param = '0;
      for (int i = 0; i < N_DIV; i++) rv_param[41*i +: 41] = r_rv[i];
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign done_slot = r_done_slot;
   assign err       = r_err;

endmodule

// File: tb/tb_vcompos_seq.sv
// Randomized self-checking bench for vcompos_seq against a transaction-level slot model.
module tb_vcompos_seq;
   localparam int N_DIV  = 5;
   localparam int N_REQ  = 2;
   localparam int TICK_W = 8;

   logic                  clk = 1'b0;
   logic                  rstz;
   logic [N_REQ-1:0]      req_vld;
   logic [N_REQ-1:0]      req_rdy;
   logic [N_REQ*3-1:0]    req_slot;
   logic [N_REQ-1:0]      req_ena;
   logic [N_REQ*24-1:0]   req_r;
   logic [N_REQ*16-1:0]   req_v;
   logic [N_REQ*16-1:0]   req_step;
   logic [TICK_W-1:0]     tick_div;
   logic                  abort;
   logic [N_DIV*41-1:0]   rv_param;
   logic [N_DIV-1:0]      busy;
   logic                  done;
   logic [2:0]            done_slot;
   logic                  err;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [40:0] mdl_rv [N_DIV];
   int          mdl_rr;

   vcompos_seq #(.N_DIV(N_DIV), .N_REQ(N_REQ), .TICK_W(TICK_W)) u_dut (
      .clk(clk), .rstz(rstz), .req_vld(req_vld), .req_rdy(req_rdy), .req_slot(req_slot),
      .req_ena(req_ena), .req_r(req_r), .req_v(req_v), .req_step(req_step),
      .tick_div(tick_div), .abort(abort), .rv_param(rv_param), .busy(busy),
      .done(done), .done_slot(done_slot), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_slots(input string tag);
      for (int i = 0; i < N_DIV; i++)
         chk($sformatf("%s_slot%0d", tag, i), 64'(rv_param[41*i +: 41]), 64'(mdl_rv[i]));
   endtask

   task automatic drive_agent(input int a, input logic [2:0] s, input logic e,
                              input logic [23:0] r, input logic [15:0] v, input logic [15:0] st);
      req_slot[3*a +: 3]  = s;
      req_ena[a]          = e;
      req_r[24*a +: 24]   = r;
      req_v[16*a +: 16]   = v;
      req_step[16*a +: 16] = st;
   endtask

   // Voltage expected c cycles after accept while ramping from v0 toward tgt
   function automatic logic [15:0] traj(input logic [15:0] v0, input logic [15:0] tgt,
                                        input logic [15:0] st, input logic [7:0] tk, input int c);
      int steps, mv, d;
      steps = (c - 2) / (int'(tk) + 1);
      mv    = steps * int'(st);
      d     = (tgt >= v0) ? int'(tgt) - int'(v0) : int'(v0) - int'(tgt);
      if (mv > d) mv = d;
      return (tgt >= v0) ? 16'(int'(v0) + mv) : 16'(int'(v0) - mv);
   endfunction

   task automatic reset_model();
      for (int i = 0; i < N_DIV; i++) mdl_rv[i] = 41'd0;
      mdl_rr = 0;
   endtask

   // ab: 0 = no abort, -1 = random abort cycle, >0 = abort asserted in that cycle after accept
   task automatic do_req(input int a, input logic [2:0] s, input logic e, input logic [23:0] r,
                         input logic [15:0] v, input logic [15:0] st, input logic [7:0] tk,
                         input int ab);
      logic [15:0] v0;
      logic [40:0] fin;
      int          d, nst, lat, ca, c, w;
      bit          ramp, exp_err;
      exp_err = (int'(s) >= N_DIV);
      ramp = 1'b0; lat = 2; v0 = 16'd0; fin = 41'd0;
      if (!exp_err) begin
         v0 = mdl_rv[s][15:0];
         if (!e || r == 24'd0) fin = {e, r, v};
         else begin
            fin = {1'b1, r, v};
            if (st != 16'd0 && v0 != v) begin
               ramp = 1'b1;
               d    = (v > v0) ? int'(v) - int'(v0) : int'(v0) - int'(v);
               nst  = (d + int'(st) - 1) / int'(st);
               lat  = 2 + nst * (int'(tk) + 1);
            end
         end
      end
      ca = ab;
      if (ab < 0) ca = ramp ? $urandom_range(2, lat - 1) : 1;
      if (ramp && ca >= 2 && ca < lat) begin
         lat       = ca + 1;
         fin[15:0] = traj(v0, v, st, tk, ca);
      end

      @(negedge clk);
      drive_agent(a, s, e, r, v, st);
      tick_div = tk;
      req_vld  = N_REQ'(1) << a;
      #1;
      w = 0;
      while (!req_rdy[a] && w < 8) begin
         @(negedge clk); #1; w++;
      end
      chk("req_rdy", 64'(req_rdy), 64'(N_REQ'(1) << a));
      @(posedge clk);
      mdl_rr = (a + 1) % N_REQ;
      @(negedge clk);
      req_vld  = '0;
      req_slot = N_REQ*3'($urandom);
      req_v    = N_REQ*16'($urandom);
      tick_div = TICK_W'($urandom);
      c = 1;
      while (c <= lat + 8) begin
         abort = (c == ca);
         if (done) break;
         if (ramp && c >= 2) begin
            chk("ramp_busy", 64'(busy[s]), 64'd1);
            chk("ramp_v", 64'(rv_param[41*s +: 16]), 64'(traj(v0, v, st, tk, c)));
         end
         @(negedge clk);
         c++;
      end
      abort = 1'b0;
      chk("done_lat", 64'(c), 64'(lat));
      chk("done_slot", 64'(done_slot), 64'(s));
      chk("err", 64'(err), 64'(exp_err));
      if (!exp_err) mdl_rv[s] = fin;
      check_slots("post");
      chk("busy_clr", 64'(busy), 64'd0);
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd0);
      chk("err_pulse", 64'(err), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      reset_model();
      check_slots(tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_dslot"}, 64'(done_slot), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
      chk({tag, "_rdy"}, 64'(req_rdy), 64'd0);
   endtask

   initial begin
      int g, exp_w;
      logic [15:0] tv;
      rstz = 1'b0; req_vld = '0; abort = 1'b0; tick_div = '0;
      req_slot = '0; req_ena = '0; req_r = '0; req_v = '0; req_step = '0;
      reset_model();
      repeat (3) @(negedge clk);
      req_vld = 2'b11;
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rstz = 1'b1; req_vld = '0;
      @(negedge clk);

      do_req(0, 3'd1, 1'b1, 24'd1000, 16'd3300, 16'd0, 8'd0, 0);
      chk("jump_fld", 64'(rv_param[41 +: 41]), 64'({1'b1, 24'd1000, 16'd3300}));
      do_req(0, 3'd0, 1'b1, 24'd500, 16'd5000, 16'd1000, 8'd3, 0);
      do_req(1, 3'd0, 1'b1, 24'd500, 16'd2500, 16'd1000, 8'd0, 0);
      do_req(0, 3'd6, 1'b1, 24'd77, 16'd999, 16'd0, 8'd0, 0);
      do_req(1, 3'd2, 1'b1, 24'd300, 16'd5000, 16'd1000, 8'd0, 4);
      chk("abort_v", 64'(rv_param[82 +: 16]), 64'd2000);

      // Both requesters held valid: grants must alternate
      @(negedge clk);
      drive_agent(0, 3'd3, 1'b1, 24'd111, 16'd1200, 16'd0);
      drive_agent(1, 3'd4, 1'b1, 24'd222, 16'd800, 16'd0);
      req_vld = 2'b11;
      g = 0; exp_w = mdl_rr;
      for (int cyc = 0; cyc < 40 && g < 4; cyc++) begin
         #1;
         chk("rdy_max1", 64'($countones(req_rdy) > 1), 64'd0);
         if (req_rdy != '0) begin
            chk("arb_grant", 64'(req_rdy), 64'(N_REQ'(1) << exp_w));
            if (exp_w == 0) mdl_rv[3] = {1'b1, 24'd111, 16'd1200};
            else            mdl_rv[4] = {1'b1, 24'd222, 16'd800};
            exp_w = (exp_w + 1) % N_REQ;
            mdl_rr = exp_w;
            g++;
         end
         @(negedge clk);
      end
      chk("arb_count", 64'(g), 64'd4);
      req_vld = '0;
      repeat (4) @(negedge clk);
      check_slots("arb");

      for (int n = 0; n < 30; n++) begin
         do_req($urandom_range(0, 1), 3'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom_range(1, 100000)),
                16'($urandom_range(0, 6000)),
                ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(150, 2500)),
                8'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? -1 : 0);
      end

      // Reset in the middle of a long ramp
      @(negedge clk);
      tv = mdl_rv[1][15:0] ^ 16'h8000;
      drive_agent(0, 3'd1, 1'b1, 24'd5, tv, 16'd1);
      tick_div = 8'd3;
      req_vld = 2'b01;
      @(posedge clk);
      @(negedge clk);
      req_vld = '0;
      repeat (5) @(negedge clk);
      chk("midramp_busy", 64'(busy[1]), 64'd1);
      rstz = 1'b0;
      req_vld = 2'b11;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      rstz = 1'b1; req_vld = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("postrst_done", 64'(done), 64'd0);
         chk("postrst_busy", 64'(busy), 64'd0);
      end
      do_req(1, 3'd4, 1'b1, 24'd42, 16'd700, 16'd300, 8'd1, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
